// File: rtl/uimac_tx_arb_pkg.sv
// uimac_tx_arb_pkg: shared stack EtherTypes and tx arbiter state encoding
package uimac_tx_arb_pkg;
  localparam logic [15:0] ETHTYPE_IP  = 16'h0800;
  localparam logic [15:0] ETHTYPE_ARP = 16'h0806;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT_DATA,
    ARB_XFER,
    ARB_GAP
  } arb_state_t;
  function automatic logic [15:0] ethtype_of(input logic arp);
    return arp ? ETHTYPE_ARP : ETHTYPE_IP;
  endfunction
endpackage

// File: rtl/uiarb_rr2.sv
// uiarb_rr2: two-way round-robin pick with last-served pointer (reset = IP last)
module uiarb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ip,
  input  logic req_arp,
  input  logic upd,
  input  logic upd_arp,
  output logic grant,
  output logic grant_arp
);
  logic last_arp;
  always_ff @(posedge clk) begin
    if (!rst_n) last_arp <= 1'b0;
    else if (upd) last_arp <= upd_arp;
  end
  always_comb begin
    grant     = req_ip | req_arp;
    grant_arp = req_arp & (~req_ip | ~last_arp);
  end
endmodule

// File: rtl/uimac_tx_arb.sv
// uimac_tx_arb: round-robin IP/ARP arbiter for the MAC tx buffer with watchdog
module uimac_tx_arb
  import uimac_tx_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT    = 16'd4096,
  parameter logic [3:0]  GAP_CYCLES = 4'd2
) (
  input  logic        I_mac_clk,
  input  logic        I_mac_reset_n,
  input  logic        I_ip_treq,
  input  logic        I_ip_tvalid,
  input  logic [7:0]  I_ip_tdata,
  input  logic [31:0] I_ip_taddr,
  output logic        O_ip_tbusy,
  input  logic        I_arp_treq,
  input  logic        I_arp_tvalid,
  input  logic [7:0]  I_arp_tdata,
  input  logic [31:0] I_arp_taddr,
  output logic        O_arp_tbusy,
  input  logic        I_mac_tbusy,
  output logic        O_mac_treq,
  output logic        O_mac_tvalid,
  output logic [7:0]  O_mac_tdata,
  output logic [31:0] O_mac_taddr,
  output logic [15:0] O_mac_ttype,
  output logic        O_arb_timeout
);
  arb_state_t  state;
  logic        win_arp;
  logic [15:0] wd_cnt;
  logic [3:0]  gap_cnt;
  logic        pick;
  logic        pick_arp;
  logic        g_tvalid;
  logic [7:0]  g_tdata;
  logic        wd_active;
  logic        wd_expired;
  logic        gap_done;
  logic        ptr_upd;
  always_comb begin
    g_tvalid   = win_arp ? I_arp_tvalid : I_ip_tvalid;
    g_tdata    = win_arp ? I_arp_tdata : I_ip_tdata;
    wd_active  = (state == ARB_REQ) || (state == ARB_WAIT_DATA);
    wd_expired = wd_active && (wd_cnt == TIMEOUT - 16'd1);
    gap_done   = (state == ARB_GAP) && !I_mac_tbusy &&
                 ({1'b0, gap_cnt} + 5'd1 >= {1'b0, GAP_CYCLES});
    ptr_upd    = wd_expired | gap_done;
  end
  uiarb_rr2 u_rr2 (
    .clk      (I_mac_clk),
    .rst_n    (I_mac_reset_n),
    .req_ip   (I_ip_treq),
    .req_arp  (I_arp_treq),
    .upd      (ptr_upd),
    .upd_arp  (win_arp),
    .grant    (pick),
    .grant_arp(pick_arp)
  );
  always_ff @(posedge I_mac_clk) begin
    if (!I_mac_reset_n) begin
      state         <= ARB_IDLE;
      win_arp       <= 1'b0;
      wd_cnt        <= 16'd0;
      gap_cnt       <= 4'd0;
      O_mac_treq    <= 1'b0;
      O_mac_tvalid  <= 1'b0;
      O_mac_tdata   <= 8'd0;
      O_mac_taddr   <= 32'd0;
      O_mac_ttype   <= 16'd0;
      O_arb_timeout <= 1'b0;
      O_ip_tbusy    <= 1'b0;
      O_arp_tbusy   <= 1'b0;
    end else begin
      O_arb_timeout <= 1'b0;
      O_mac_tvalid  <= 1'b0;
      wd_cnt        <= wd_active ? wd_cnt + 16'd1 : 16'd0;
      if (wd_expired) begin
        O_arb_timeout <= 1'b1;
        O_mac_treq    <= 1'b0;
        O_ip_tbusy    <= 1'b0;
        O_arp_tbusy   <= 1'b0;
        wd_cnt        <= 16'd0;
        gap_cnt       <= 4'd0;
        state         <= ARB_GAP;
      end else begin
        case (state)
          ARB_IDLE: begin
            if (pick) begin
              win_arp     <= pick_arp;
              O_mac_taddr <= pick_arp ? I_arp_taddr : I_ip_taddr;
              O_mac_ttype <= ethtype_of(pick_arp);
              O_mac_treq  <= 1'b1;
              state       <= ARB_REQ;
            end
          end
          ARB_REQ: begin
            if (I_mac_tbusy) begin
              O_mac_treq  <= 1'b0;
              O_ip_tbusy  <= ~win_arp;
              O_arp_tbusy <= win_arp;
              wd_cnt      <= 16'd0;
              state       <= ARB_WAIT_DATA;
            end
          end
          ARB_WAIT_DATA: begin
            if (g_tvalid) begin
              O_mac_tvalid <= 1'b1;
              O_mac_tdata  <= g_tdata;
              state        <= ARB_XFER;
            end
          end
          ARB_XFER: begin
            O_mac_tvalid <= g_tvalid;
            O_mac_tdata  <= g_tvalid ? g_tdata : O_mac_tdata;
            if (!g_tvalid) begin
              O_ip_tbusy  <= 1'b0;
              O_arp_tbusy <= 1'b0;
              gap_cnt     <= 4'd0;
              state       <= ARB_GAP;
            end
          end
          ARB_GAP: begin
            if (gap_done) state <= ARB_IDLE;
            else if (!I_mac_tbusy) gap_cnt <= gap_cnt + 4'd1;
          end
          default: state <= ARB_IDLE;
        endcase
      end
    end
  end
endmodule
